// File: rtl/psw_lock_param_pkg.sv
// Shared constants and helpers for the parametrised password lock.
// State encodings, default digit width and a digit-extraction helper.
package psw_pkg;

    // FSM state encodings (3 bits, exposed on the debug state output)
    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_ENTRY   = 3'd1;
    localparam logic [2:0] ST_CHECK   = 3'd2;
    localparam logic [2:0] ST_OPEN    = 3'd3;
    localparam logic [2:0] ST_FAIL    = 3'd4;
    localparam logic [2:0] ST_LOCKOUT = 3'd5;

    // Default bits per digit
    localparam int PSW_DIG_W = 4;

    // Widest packed code the helper accepts; callers zero-extend into it
    localparam int PSW_MAX_BITS = 256;

    // Extract digit idx (0 = first digit, held in the MSBs) from a packed
    // code of len digits, each dig_w bits wide.
    function automatic logic [15:0] code_digit(input logic [PSW_MAX_BITS-1:0] vec,
                                               input int len,
                                               input int dig_w,
                                               input int idx);
        logic [PSW_MAX_BITS-1:0] sh;
        logic [15:0]             mask;
        sh   = vec >> ((len - 1 - idx) * dig_w);
        mask = 16'((32'd1 << dig_w) - 32'd1);
        return sh[15:0] & mask;
    endfunction

endpackage

// File: rtl/psw_lock_param_if.sv
// Keypad/status bundle between the password lock and its surroundings.
// Handshake: there is no valid/ready pair; key is a level bus where a press
// is the first nonzero value after all-zero, relock and code_load are
// single-cycle pulses sampled on the rising clock edge, and all status
// outputs are registered and valid for the whole cycle after each edge.
interface psw_lock_param_if #(
    parameter int NUM_KEYS = 10,
    parameter int DIG_W    = 4,
    parameter int CODE_LEN = 4
);
    logic [NUM_KEYS-1:0]               key;
    logic                              relock;
    logic [CODE_LEN*DIG_W-1:0]         code_in;
    logic                              code_load;
    logic                              unlocked;
    logic                              error;
    logic                              locked_out;
    logic [$clog2(CODE_LEN+1)-1:0]     digit_cnt;
    logic [CODE_LEN*DIG_W-1:0]         digits;
    logic [2:0]                        state;

    // Keypad / controller side
    modport master (
        output key, relock, code_in, code_load,
        input  unlocked, error, locked_out, digit_cnt, digits, state
    );

    // Lock side
    modport slave (
        input  key, relock, code_in, code_load,
        output unlocked, error, locked_out, digit_cnt, digits, state
    );
endinterface

// File: rtl/psw_lock_param_key_encoder.sv
// Keypad press detector: registers the previous key levels and flags a
// press on the first nonzero value after a full release. Reports the digit
// index and whether more than one key is down at once.
module psw_key_encoder
    import psw_pkg::*;
#(
    parameter int NUM_KEYS = 10,
    parameter int DIG_W    = PSW_DIG_W
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NUM_KEYS-1:0] key_i,
    output logic                press_o,
    output logic [DIG_W-1:0]    digit_o,
    output logic                multi_o
);

    logic [NUM_KEYS-1:0] key_prev_q;

    // Track key levels every cycle regardless of lock state
    always_ff @(posedge clk) begin
        if (rst) begin
            key_prev_q <= '0;
        end else begin
            key_prev_q <= key_i;
        end
    end

    // Press on release->pressed transition; digit is the set bit's index
    always_comb begin
        press_o = (key_prev_q == '0) && (key_i != '0);
        multi_o = (key_i & (key_i - NUM_KEYS'(1))) != '0;
        digit_o = '0;
        for (int i = 0; i < NUM_KEYS; i++) begin
            if (key_i[i]) begin
                digit_o = DIG_W'(i);
            end
        end
    end

endmodule

// File: rtl/psw_lock_param.sv
// Parametrised password lock: collects CODE_LEN digits, checks them against
// the stored code and drives open / error / lockout status. Includes failure
// counting with timed lockout, entry inactivity timeout and a timed open
// window. Optional macro PSW_CODE_LOAD_EN allows reloading the code in OPEN.
module psw_lock_param
    import psw_pkg::*;
#(
    parameter int NUM_KEYS       = 10,
    parameter int DIG_W          = PSW_DIG_W,
    parameter int CODE_LEN       = 4,
    parameter logic [CODE_LEN*DIG_W-1:0] CODE = {4'd2, 4'd0, 4'd1, 4'd6},
    parameter int MAX_FAIL       = 3,
    parameter int LOCKOUT_CYCLES = 1000,
    parameter int OPEN_CYCLES    = 500,
    parameter int ENTRY_TIMEOUT  = 2000
) (
    input  logic            clk,
    input  logic            rst,
    psw_lock_param_if.slave bus
);

    localparam int CODE_W  = CODE_LEN * DIG_W;
    localparam int CNT_W   = $clog2(CODE_LEN + 1);
    localparam int FAIL_W  = $clog2(MAX_FAIL + 1);
    localparam int TMR_MAX = (LOCKOUT_CYCLES > OPEN_CYCLES)
                           ? ((LOCKOUT_CYCLES > ENTRY_TIMEOUT) ? LOCKOUT_CYCLES : ENTRY_TIMEOUT)
                           : ((OPEN_CYCLES > ENTRY_TIMEOUT) ? OPEN_CYCLES : ENTRY_TIMEOUT);
    localparam int TMR_W   = $clog2(TMR_MAX + 1);

    logic [2:0]        state_q, state_d;
    logic [CODE_W-1:0] digits_q, digits_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              mism_q, mism_d;
    logic [FAIL_W-1:0] fail_q, fail_d;
    logic [TMR_W-1:0]  timer_q, timer_d;
    logic              unlocked_q, error_q, locked_out_q;

    logic              press, multi;
    logic [DIG_W-1:0]  key_digit;
    logic [CODE_W-1:0] stored_code;
    logic [CODE_W-1:0] digits_store;
    logic [DIG_W-1:0]  slot_val;
    logic              slot_bad;

    psw_key_encoder #(
        .NUM_KEYS (NUM_KEYS),
        .DIG_W    (DIG_W)
    ) u_enc (
        .clk     (clk),
        .rst     (rst),
        .key_i   (bus.key),
        .press_o (press),
        .digit_o (key_digit),
        .multi_o (multi)
    );

`ifdef PSW_CODE_LOAD_EN
    logic [CODE_W-1:0] code_q;

    // Latch a new code only while the lock is open
    always_ff @(posedge clk) begin
        if (rst) begin
            code_q <= CODE;
        end else if (state_q == ST_OPEN && bus.code_load) begin
            code_q <= bus.code_in;
        end
    end

    assign stored_code = code_q;
`else
    logic unused_code_inputs;

    assign stored_code        = CODE;
    assign unused_code_inputs = ^{bus.code_in, bus.code_load};
`endif

    // Value written into the current slot and whether it breaks the match;
    // a multi-key press stores 0 but always counts as a mismatch.
    always_comb begin
        slot_val     = multi ? '0 : key_digit;
        slot_bad     = multi;
        digits_store = digits_q;
        for (int i = 0; i < CODE_LEN; i++) begin
            if (i == int'(cnt_q)) begin
                digits_store[(CODE_LEN-1-i)*DIG_W +: DIG_W] = slot_val;
                slot_bad = multi ||
                    (key_digit != DIG_W'(code_digit(PSW_MAX_BITS'(stored_code), CODE_LEN, DIG_W, i)));
            end
        end
    end

    // Next-state, slot, failure-count and timer logic
    always_comb begin
        state_d  = state_q;
        digits_d = digits_q;
        cnt_d    = cnt_q;
        mism_d   = mism_q;
        fail_d   = fail_q;
        timer_d  = (timer_q < TMR_W'(TMR_MAX)) ? timer_q + TMR_W'(1) : timer_q;

        case (state_q)
            ST_IDLE: begin
                if (press) begin
                    digits_d = digits_store;
                    cnt_d    = CNT_W'(1);
                    mism_d   = slot_bad;
                    timer_d  = '0;
                    state_d  = (CODE_LEN == 1) ? ST_CHECK : ST_ENTRY;
                end
            end
            ST_ENTRY: begin
                if (press) begin
                    digits_d = digits_store;
                    cnt_d    = cnt_q + CNT_W'(1);
                    mism_d   = mism_q | slot_bad;
                    timer_d  = '0;
                    if (int'(cnt_q) == CODE_LEN - 1) begin
                        state_d = ST_CHECK;
                    end
                end else if (timer_q == TMR_W'(ENTRY_TIMEOUT - 1)) begin
                    // Abandoned entry: not counted as a failure
                    state_d  = ST_IDLE;
                    digits_d = '0;
                    cnt_d    = '0;
                    mism_d   = 1'b0;
                    timer_d  = '0;
                end
            end
            ST_CHECK: begin
                timer_d = '0;
                if (!mism_q) begin
                    state_d = ST_OPEN;
                    fail_d  = '0;
                end else if (int'(fail_q) + 1 >= MAX_FAIL) begin
                    // Lockout starts with a clean buffer so ignored presses show 0
                    state_d  = ST_LOCKOUT;
                    fail_d   = '0;
                    digits_d = '0;
                    cnt_d    = '0;
                end else begin
                    state_d = ST_FAIL;
                    fail_d  = fail_q + FAIL_W'(1);
                end
            end
            ST_OPEN: begin
                if (bus.relock || timer_q == TMR_W'(OPEN_CYCLES - 1)) begin
                    state_d  = ST_IDLE;
                    digits_d = '0;
                    cnt_d    = '0;
                    timer_d  = '0;
                end
            end
            ST_FAIL: begin
                state_d  = ST_IDLE;
                digits_d = '0;
                cnt_d    = '0;
                timer_d  = '0;
            end
            ST_LOCKOUT: begin
                if (timer_q == TMR_W'(LOCKOUT_CYCLES - 1)) begin
                    state_d = ST_IDLE;
                    timer_d = '0;
                end
            end
            default: begin
                state_d  = ST_IDLE;
                digits_d = '0;
                cnt_d    = '0;
                mism_d   = 1'b0;
                timer_d  = '0;
            end
        endcase
    end

    // State and datapath registers; status outputs registered from next state
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            digits_q     <= '0;
            cnt_q        <= '0;
            mism_q       <= 1'b0;
            fail_q       <= '0;
            timer_q      <= '0;
            unlocked_q   <= 1'b0;
            error_q      <= 1'b0;
            locked_out_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            digits_q     <= digits_d;
            cnt_q        <= cnt_d;
            mism_q       <= mism_d;
            fail_q       <= fail_d;
            timer_q      <= timer_d;
            unlocked_q   <= (state_d == ST_OPEN);
            error_q      <= (state_d == ST_FAIL);
            locked_out_q <= (state_d == ST_LOCKOUT);
        end
    end

    assign bus.unlocked   = unlocked_q;
    assign bus.error      = error_q;
    assign bus.locked_out = locked_out_q;
    assign bus.digit_cnt  = cnt_q;
    assign bus.digits     = digits_q;
    assign bus.state      = state_q;

endmodule

// File: tb/tb_psw_lock_param.sv
// Directed bench for psw_lock_param with the default parameters
// (code 2-0-1-6, 3 failures, 1000/500/2000 cycle timers).
module tb_psw_lock_param;

    logic clk;
    logic rst;
    int   vec_cnt;
    int   err_cnt;

    psw_lock_param_if #(.NUM_KEYS(10), .DIG_W(4), .CODE_LEN(4)) bus ();

    psw_lock_param dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one edge and let registered outputs settle
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
    endtask

    // One press then a full release
    task automatic press(input logic [9:0] k);
        bus.key = k;
        tick();
        bus.key = '0;
        tick();
    endtask

    // Enter four digits, first digit in the MSB nibble
    task automatic enter_code(input logic [15:0] c);
        for (int i = 3; i >= 0; i--) begin
            press(10'b1 << c[i*4 +: 4]);
        end
    endtask

    task automatic relock_pulse();
        bus.relock = 1'b1;
        tick();
        bus.relock = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        vec_cnt++; if (bus.state !== 3'd0) begin err_cnt++; $display("FAIL reset_state got %0d want 0", bus.state); end
        vec_cnt++; if (bus.unlocked !== 1'b0) begin err_cnt++; $display("FAIL reset_unlocked got %b want 0", bus.unlocked); end
        vec_cnt++; if (bus.error !== 1'b0) begin err_cnt++; $display("FAIL reset_error got %b want 0", bus.error); end
        vec_cnt++; if (bus.locked_out !== 1'b0) begin err_cnt++; $display("FAIL reset_locked got %b want 0", bus.locked_out); end
        vec_cnt++; if (bus.digit_cnt !== 3'd0) begin err_cnt++; $display("FAIL reset_cnt got %0d want 0", bus.digit_cnt); end
        vec_cnt++; if (bus.digits !== 16'h0000) begin err_cnt++; $display("FAIL reset_digits got %h want 0000", bus.digits); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_unlock();
        press(10'b1 << 2);
        vec_cnt++; if (bus.state !== 3'd1) begin err_cnt++; $display("FAIL unl_state1 got %0d want 1", bus.state); end
        vec_cnt++; if (bus.digit_cnt !== 3'd1) begin err_cnt++; $display("FAIL unl_cnt1 got %0d want 1", bus.digit_cnt); end
        vec_cnt++; if (bus.digits !== 16'h2000) begin err_cnt++; $display("FAIL unl_dig1 got %h want 2000", bus.digits); end
        press(10'b1 << 0);
        vec_cnt++; if (bus.digit_cnt !== 3'd2) begin err_cnt++; $display("FAIL unl_cnt2 got %0d want 2", bus.digit_cnt); end
        press(10'b1 << 1);
        vec_cnt++; if (bus.digit_cnt !== 3'd3) begin err_cnt++; $display("FAIL unl_cnt3 got %0d want 3", bus.digit_cnt); end
        vec_cnt++; if (bus.digits !== 16'h2010) begin err_cnt++; $display("FAIL unl_dig3 got %h want 2010", bus.digits); end
        bus.key = 10'b1 << 6;
        tick();
        vec_cnt++; if (bus.state !== 3'd2) begin err_cnt++; $display("FAIL unl_check got %0d want 2", bus.state); end
        vec_cnt++; if (bus.unlocked !== 1'b0) begin err_cnt++; $display("FAIL unl_early got %b want 0", bus.unlocked); end
        vec_cnt++; if (bus.digit_cnt !== 3'd4) begin err_cnt++; $display("FAIL unl_cnt4 got %0d want 4", bus.digit_cnt); end
        vec_cnt++; if (bus.digits !== 16'h2016) begin err_cnt++; $display("FAIL unl_dig4 got %h want 2016", bus.digits); end
        bus.key = '0;
        tick();
        vec_cnt++; if (bus.state !== 3'd3) begin err_cnt++; $display("FAIL unl_open got %0d want 3", bus.state); end
        vec_cnt++; if (bus.unlocked !== 1'b1) begin err_cnt++; $display("FAIL unl_high got %b want 1", bus.unlocked); end
        // Keys ignored while open
        press(10'b1 << 4);
        vec_cnt++; if (bus.digit_cnt !== 3'd4) begin err_cnt++; $display("FAIL unl_keyign got %0d want 4", bus.digit_cnt); end
        repeat (497) tick();
        vec_cnt++; if (bus.unlocked !== 1'b1) begin err_cnt++; $display("FAIL unl_last got %b want 1", bus.unlocked); end
        tick();
        vec_cnt++; if (bus.unlocked !== 1'b0) begin err_cnt++; $display("FAIL unl_drop got %b want 0", bus.unlocked); end
        vec_cnt++; if (bus.state !== 3'd0) begin err_cnt++; $display("FAIL unl_idle got %0d want 0", bus.state); end
        vec_cnt++; if (bus.digit_cnt !== 3'd0) begin err_cnt++; $display("FAIL unl_clr got %0d want 0", bus.digit_cnt); end
        // Relock outside OPEN is ignored
        relock_pulse();
        vec_cnt++; if (bus.state !== 3'd0) begin err_cnt++; $display("FAIL relock_idle got %0d want 0", bus.state); end
    endtask

    task automatic test_fail_lockout();
        enter_code(16'h2017);
        vec_cnt++; if (bus.state !== 3'd4) begin err_cnt++; $display("FAIL f1_state got %0d want 4", bus.state); end
        vec_cnt++; if (bus.error !== 1'b1) begin err_cnt++; $display("FAIL f1_error got %b want 1", bus.error); end
        tick();
        vec_cnt++; if (bus.state !== 3'd0) begin err_cnt++; $display("FAIL f1_idle got %0d want 0", bus.state); end
        vec_cnt++; if (bus.error !== 1'b0) begin err_cnt++; $display("FAIL f1_pulse got %b want 0", bus.error); end
        vec_cnt++; if (bus.digits !== 16'h0000) begin err_cnt++; $display("FAIL f1_digits got %h want 0000", bus.digits); end
        enter_code(16'h2017);
        vec_cnt++; if (bus.state !== 3'd4) begin err_cnt++; $display("FAIL f2_state got %0d want 4", bus.state); end
        tick();
        enter_code(16'h2017);
        vec_cnt++; if (bus.state !== 3'd5) begin err_cnt++; $display("FAIL f3_lock got %0d want 5", bus.state); end
        vec_cnt++; if (bus.locked_out !== 1'b1) begin err_cnt++; $display("FAIL f3_lockout got %b want 1", bus.locked_out); end
        vec_cnt++; if (bus.error !== 1'b0) begin err_cnt++; $display("FAIL f3_noerr got %b want 0", bus.error); end
        press(10'b1 << 3);
        press(10'b1 << 4);
        vec_cnt++; if (bus.digit_cnt !== 3'd0) begin err_cnt++; $display("FAIL lock_keys got %0d want 0", bus.digit_cnt); end
        repeat (995) tick();
        vec_cnt++; if (bus.locked_out !== 1'b1) begin err_cnt++; $display("FAIL lock_last got %b want 1", bus.locked_out); end
        // Key held across the lockout exit must not register
        bus.key = 10'b1 << 5;
        tick();
        vec_cnt++; if (bus.locked_out !== 1'b0) begin err_cnt++; $display("FAIL lock_drop got %b want 0", bus.locked_out); end
        vec_cnt++; if (bus.state !== 3'd0) begin err_cnt++; $display("FAIL lock_idle got %0d want 0", bus.state); end
        tick();
        tick();
        vec_cnt++; if (bus.digit_cnt !== 3'd0) begin err_cnt++; $display("FAIL hold_cnt got %0d want 0", bus.digit_cnt); end
        vec_cnt++; if (bus.state !== 3'd0) begin err_cnt++; $display("FAIL hold_state got %0d want 0", bus.state); end
        bus.key = '0;
        tick();
        press(10'b1 << 2);
        vec_cnt++; if (bus.digit_cnt !== 3'd1) begin err_cnt++; $display("FAIL after_rel got %0d want 1", bus.digit_cnt); end
        do_reset();
    endtask

    task automatic test_fail_count_clear();
        enter_code(16'h1111);
        tick();
        enter_code(16'h2222);
        tick();
        enter_code(16'h2016);
        vec_cnt++; if (bus.state !== 3'd3) begin err_cnt++; $display("FAIL wwc_open got %0d want 3", bus.state); end
        relock_pulse();
        vec_cnt++; if (bus.state !== 3'd0) begin err_cnt++; $display("FAIL wwc_relock got %0d want 0", bus.state); end
        enter_code(16'h3333);
        vec_cnt++; if (bus.state !== 3'd4) begin err_cnt++; $display("FAIL wwc_w1 got %0d want 4", bus.state); end
        tick();
        enter_code(16'h4444);
        vec_cnt++; if (bus.state !== 3'd4) begin err_cnt++; $display("FAIL wwc_w2 got %0d want 4", bus.state); end
        vec_cnt++; if (bus.locked_out !== 1'b0) begin err_cnt++; $display("FAIL wwc_nolock got %b want 0", bus.locked_out); end
        tick();
        do_reset();
    endtask

    task automatic test_multi_key();
        press(10'b0000000101);
        vec_cnt++; if (bus.digit_cnt !== 3'd1) begin err_cnt++; $display("FAIL multi_cnt got %0d want 1", bus.digit_cnt); end
        vec_cnt++; if (bus.digits !== 16'h0000) begin err_cnt++; $display("FAIL multi_slot got %h want 0000", bus.digits); end
        press(10'b1 << 0);
        press(10'b1 << 1);
        vec_cnt++; if (bus.digits !== 16'h0010) begin err_cnt++; $display("FAIL multi_dig3 got %h want 0010", bus.digits); end
        press(10'b1 << 6);
        vec_cnt++; if (bus.error !== 1'b1) begin err_cnt++; $display("FAIL multi_err got %b want 1", bus.error); end
        tick();
        do_reset();
    endtask

    task automatic test_timeout();
        press(10'b1 << 2);
        repeat (1998) tick();
        vec_cnt++; if (bus.state !== 3'd1) begin err_cnt++; $display("FAIL to_still got %0d want 1", bus.state); end
        vec_cnt++; if (bus.digit_cnt !== 3'd1) begin err_cnt++; $display("FAIL to_cnt1 got %0d want 1", bus.digit_cnt); end
        tick();
        vec_cnt++; if (bus.state !== 3'd0) begin err_cnt++; $display("FAIL to_idle got %0d want 0", bus.state); end
        vec_cnt++; if (bus.digit_cnt !== 3'd0) begin err_cnt++; $display("FAIL to_cnt0 got %0d want 0", bus.digit_cnt); end
        vec_cnt++; if (bus.digits !== 16'h0000) begin err_cnt++; $display("FAIL to_digits got %h want 0000", bus.digits); end
        vec_cnt++; if (bus.error !== 1'b0) begin err_cnt++; $display("FAIL to_error got %b want 0", bus.error); end
    endtask

    task automatic test_rst_mid();
        enter_code(16'h5555);
        tick();
        enter_code(16'h5555);
        tick();
        press(10'b1 << 2);
        press(10'b1 << 0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        vec_cnt++; if (bus.digit_cnt !== 3'd0) begin err_cnt++; $display("FAIL rstmid_cnt got %0d want 0", bus.digit_cnt); end
        vec_cnt++; if (bus.state !== 3'd0) begin err_cnt++; $display("FAIL rstmid_state got %0d want 0", bus.state); end
        tick();
        enter_code(16'h5555);
        tick();
        enter_code(16'h5555);
        vec_cnt++; if (bus.state !== 3'd4) begin err_cnt++; $display("FAIL rstmid_fcnt got %0d want 4", bus.state); end
        tick();
        do_reset();
    endtask

    task automatic test_code_load();
        enter_code(16'h2016);
        vec_cnt++; if (bus.state !== 3'd3) begin err_cnt++; $display("FAIL cl_open got %0d want 3", bus.state); end
        bus.code_in   = 16'h9999;
        bus.code_load = 1'b1;
        tick();
        bus.code_load = 1'b0;
        relock_pulse();
        vec_cnt++; if (bus.state !== 3'd0) begin err_cnt++; $display("FAIL cl_relock got %0d want 0", bus.state); end
        enter_code(16'h9999);
`ifdef PSW_CODE_LOAD_EN
        vec_cnt++; if (bus.state !== 3'd3) begin err_cnt++; $display("FAIL cl_new got %0d want 3", bus.state); end
        relock_pulse();
        press(10'b1 << 2);
        press(10'b1 << 0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        vec_cnt++; if (bus.digit_cnt !== 3'd0) begin err_cnt++; $display("FAIL cl_rstcnt got %0d want 0", bus.digit_cnt); end
        tick();
`else
        vec_cnt++; if (bus.state !== 3'd4) begin err_cnt++; $display("FAIL cl_ignored got %0d want 4", bus.state); end
        tick();
`endif
        enter_code(16'h2016);
        vec_cnt++; if (bus.state !== 3'd3) begin err_cnt++; $display("FAIL cl_orig got %0d want 3", bus.state); end
        do_reset();
    endtask

    initial begin
        vec_cnt       = 0;
        err_cnt       = 0;
        rst           = 1'b1;
        bus.key       = '0;
        bus.relock    = 1'b0;
        bus.code_in   = '0;
        bus.code_load = 1'b0;
        test_reset();
        test_unlock();
        test_fail_lockout();
        test_fail_count_clear();
        test_multi_key();
        test_timeout();
        test_rst_mid();
        test_code_load();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule

// File: doc/psw_lock_param.md
Name: psw_lock_param

Overview:
Parametrised successor to the fixed 4-digit password FSM. Consumes debounced one-hot keypad switches and assembles a CODE_LEN-digit entry. Compares the entry against a stored code and drives unlock, error and lockout status plus the entered-digit buffer that the top level feeds to the seven-segment decoders. Adds failure counting with timed lockout, an entry inactivity timeout and a timed open window.

Parameters:
- NUM_KEYS, 10, number of one-hot key inputs; digit value = key index.
- DIG_W, 4, bits per digit; NUM_KEYS <= 2**DIG_W.
- CODE_LEN, 4, digits per code, >=1.
- CODE, {4'd2,4'd0,4'd1,4'd6}, reset code, packed CODE_LEN*DIG_W; first digit in MSBs.
- MAX_FAIL, 3, consecutive failures that trigger lockout, >=1.
- LOCKOUT_CYCLES, 1000, lockout duration in clk cycles.
- OPEN_CYCLES, 500, unlocked window in clk cycles.
- ENTRY_TIMEOUT, 2000, idle cycles in ENTRY before the entry is abandoned.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous active-high reset.
- key  in  NUM_KEYS  debounced key levels, one-hot when pressed.
- relock  in  1  pulse: leave OPEN immediately.
- code_in  in  CODE_LEN*DIG_W  new code (used only with PSW_CODE_LOAD_EN).
- code_load  in  1  pulse: latch code_in (used only with PSW_CODE_LOAD_EN).
- unlocked  out  1  high in OPEN.
- error  out  1  one-cycle pulse on a failed check.
- locked_out  out  1  high in LOCKOUT.
- digit_cnt  out  $clog2(CODE_LEN+1)  digits entered so far.
- digits  out  CODE_LEN*DIG_W  entered digits, first digit in MSBs, unused slots 0.
- state  out  3  FSM state encoding, for debug and bench probing.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high (rst).
- Reset values: state=IDLE; all outputs 0; fail_cnt=0; timers=0; key_prev=0; stored code=CODE.
- Press detection:
  - key_prev is registered every cycle.
  - Press event = (key_prev==0) && (key!=0).
  - Exactly one bit set: valid digit = index.
  - More than one bit set: bad digit. It occupies a slot with value 0 and forces a mismatch.
  - Key changes while key_prev!=0 are ignored, so a digit is only accepted after full release.
- States: IDLE=0, ENTRY=1, CHECK=2, OPEN=3, FAIL=4, LOCKOUT=5. All outputs are registered; Moore outputs follow the state.
- IDLE:
  - Press: store the digit in slot 0, digit_cnt=1, go to ENTRY.
  - If CODE_LEN==1, go directly to CHECK instead.
- ENTRY:
  - Each press stores into slot digit_cnt and increments digit_cnt.
  - A sticky mismatch flag is updated per digit.
  - The press that fills slot CODE_LEN-1 moves the FSM to CHECK.
  - Inactivity counter resets on each press. On reaching ENTRY_TIMEOUT: go to IDLE, clear digits and digit_cnt. This is not a failure.
- CHECK (1 cycle; presses ignored):
  - Match: go to OPEN, fail_cnt=0.
  - Mismatch with fail_cnt+1==MAX_FAIL: go to LOCKOUT, fail_cnt=0.
  - Otherwise: go to FAIL, fail_cnt++.
- OPEN:
  - unlocked=1 for OPEN_CYCLES cycles, or until relock, whichever comes first; then IDLE.
  - Keys ignored. digits and digit_cnt are cleared on exit.
- FAIL: error=1 for exactly this cycle. Next cycle: IDLE, digits cleared.
- LOCKOUT:
  - locked_out=1 for LOCKOUT_CYCLES cycles, then IDLE.
  - Keys ignored; key_prev keeps tracking, so a key held across the exit does not register.
- Latency: last digit sampled at edge N → CHECK after N → unlocked, error or locked_out visible after edge N+1.
- Counters are sized $clog2(max+1) and saturate; there is no wrap.
- rst mid-operation returns to the reset values within one edge, including fail_cnt.
- relock outside OPEN is ignored.

Optional Feature:
- PSW_CODE_LOAD_EN defined:
  - code_load while in OPEN latches code_in as the stored code on that edge. The new code is used by the next CHECK.
  - code_load in any other state is ignored.
  - rst restores CODE.
- Undefined: stored code is the constant CODE; code_in and code_load are unconnected inputs with no effect.

Decomposition:
- Package psw_pkg holds:
  - state enum constants (IDLE..LOCKOUT, 3 bits);
  - DIG_W default;
  - a helper function that extracts digit i from a packed code vector.
- One sub-module, psw_key_encoder: registers key_prev and produces press, digit[DIG_W-1:0] and multi (more than one bit set).
- FSM, timers and compare stay in psw_lock_param.

Test Plan:
- Keys 2,0,1,6 (one-hot pulse, release between each) → digit_cnt steps 1..4; unlocked=1 one edge after CHECK; drops after 500 cycles; state returns to 0.
- Keys 2,0,1,7 → error pulses for 1 cycle, state FAIL→IDLE, digits cleared; repeat twice more → locked_out=1 for 1000 cycles; presses during lockout leave digit_cnt=0.
- Wrong, wrong, correct → OPEN and fail_cnt=0; a following wrong then wrong produces no lockout.
- key=10'b0000000101 as first press → slot 0 =0, the remaining three correct digits still fail (error=1).
- Press 2 then hold no key for 2000 cycles → IDLE, digit_cnt=0, no error; hold a key through lockout exit → no digit accepted.
- PSW_CODE_LOAD_EN: open with 2016; code_load with code_in=16'h9999; relock; enter 9,9,9,9 → unlocked. rst mid-entry → digit_cnt=0, code reverts to 2016.
